// File: rtl/flag_bank_pkg.sv
// Shared op encodings and helpers for the flag bank scheduler.
package flag_bank_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
  localparam logic [OP_W-1:0] OP_CLR  = 2'b01;
  localparam logic [OP_W-1:0] OP_PRE  = 2'b10;
  localparam logic [OP_W-1:0] OP_TGL  = 2'b11;

  // Next round-robin position after v in a ring of n slots.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/flag_bank_sched_rr_arbiter.sv
// Round-robin arbiter: combinational winner search from the pointer, registered pointer.
module rr_arbiter
  import flag_bank_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] elig,
  output logic         win_vld,
  output logic [N-1:0] win_onehot,
  output logic [W-1:0] win_idx
);

  logic [W-1:0] ptr;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    int cand;
    cand       = 0;
    win_vld    = 1'b0;
    win_onehot = '0;
    win_idx    = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        cand = (int'(ptr) + k) % N;
        if (!win_vld && elig[cand]) begin
          win_vld          = 1'b1;
          win_onehot[cand] = 1'b1;
          win_idx          = W'(cand);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (win_vld) begin
      ptr <= W'(wrap_inc(int'(win_idx), N));
    end
  end

endmodule

// File: rtl/flag_bank_sched.sv
// Flag bank with set/clear/preset/toggle ops, shared among requesters by a round-robin arbiter.
module flag_bank_sched
  import flag_bank_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req,
  input  logic [OP_W*NREQ-1:0]   op,
  input  logic [IDXW*NREQ-1:0]   idx,
  input  logic [NREQ-1:0]        d,
  output logic [NREQ-1:0]        gnt,
  output logic                   upd_vld,
  output logic [IDXW-1:0]        upd_idx,
  output logic [NFLAG-1:0]       q,
  output logic [NFLAG-1:0]       p
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FW = (NFLAG > 1) ? $clog2(NFLAG) : 1;

  logic [NREQ-1:0] elig;
  logic            win_vld;
  logic [NREQ-1:0] win_onehot;
  logic [RW-1:0]   win_idx;

  logic [OP_W-1:0] sel_op;
  logic [IDXW-1:0] sel_idx;
  logic            sel_d;
  logic            sel_in_range;
  logic [FW-1:0]   flag_idx;

  // A requester holding its grant this cycle is not re-arbitrated at this edge.
  assign elig = req & ~gnt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (~hold),
    .elig       (elig),
    .win_vld    (win_vld),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  always_comb begin
    sel_op       = op[OP_W*int'(win_idx) +: OP_W];
    sel_idx      = idx[IDXW*int'(win_idx) +: IDXW];
    sel_d        = d[win_idx];
    sel_in_range = int'(sel_idx) < NFLAG;
    flag_idx     = FW'(sel_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      upd_vld <= 1'b0;
      upd_idx <= '0;
      q       <= '0;
      p       <= '1;
    end else begin
      gnt     <= win_onehot;
      upd_vld <= win_vld;
      p       <= ~q;
      if (win_vld) begin
        upd_idx <= sel_idx;
        // Out-of-range indices are granted and reported but leave the bank alone.
        if (sel_in_range) begin
          case (sel_op)
            OP_LOAD: q[flag_idx] <= sel_d;
            OP_CLR:  q[flag_idx] <= 1'b0;
            OP_PRE:  q[flag_idx] <= 1'b1;
            default: q[flag_idx] <= ~q[flag_idx];
          endcase
        end
      end
    end
  end

endmodule
